// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte over the
// open-drain PS/2 clock/data lines and checks the device acknowledge.
//
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   tx_start, tx_data one-cycle send request and the byte to send
//   ps2c_in, ps2d_in  raw PS/2 clock/data line levels
//   ps2c_oe, ps2d_oe  1 = pull line low, 0 = release
//   tx_busy           high from acceptance until back in IDLE
//   tx_done, tx_err   one-cycle completion / failure pulses
//
// Optional build macro: PS2_TX_RETRY_EN (one automatic retry on error).
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int MAX_IS = (INHIBIT_CYCLES > SETUP_CYCLES) ?
                            INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int MAXP   = (MAX_IS > TIMEOUT_CYCLES) ?
                            MAX_IS : TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    sh_q, sh_d;
    logic          c_s1_q, c_s2_q, c_s3_q;
    logic          d_s1_q, d_s2_q;
    logic          c_oe_q, c_oe_d;
    logic          d_oe_q, d_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          fall;
    logic          fail;
`ifdef PS2_TX_RETRY_EN
    logic [7:0]    byte_q, byte_d;
    logic          retry_q, retry_d;
`endif

    // Device clock falling edge, seen on the synchronised line.
    assign fall = c_s3_q & ~c_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_s1_q <= 1'b1;
            c_s2_q <= 1'b1;
            c_s3_q <= 1'b1;
            d_s1_q <= 1'b1;
            d_s2_q <= 1'b1;
        end else begin
            c_s1_q <= ps2c_in;
            c_s2_q <= c_s1_q;
            c_s3_q <= c_s2_q;
            d_s1_q <= ps2d_in;
            d_s2_q <= d_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            c_oe_q  <= 1'b0;
            d_oe_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            c_oe_q  <= c_oe_d;
            d_oe_q  <= d_oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q  <= '0;
            retry_q <= 1'b0;
        end else begin
            byte_q  <= byte_d;
            retry_q <= retry_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        c_oe_d  = c_oe_q;
        d_oe_d  = d_oe_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        fail    = 1'b0;
`ifdef PS2_TX_RETRY_EN
        byte_d  = byte_q;
        retry_d = retry_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    sh_d    = {~^tx_data, tx_data};
                    busy_d  = 1'b1;
                    c_oe_d  = 1'b1;
                    d_oe_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    byte_d  = tx_data;
                    retry_d = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    d_oe_d  = 1'b1;
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REQ: begin
                if (cnt_q == SET_LAST) begin
                    cnt_d   = '0;
                    c_oe_d  = 1'b0;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (fall) begin
                    cnt_d = '0;
                    if (bit_q == 4'd9) begin
                        // Edge 10: release data as the stop bit.
                        d_oe_d  = 1'b0;
                        state_d = S_ACK;
                    end else begin
                        d_oe_d = ~sh_q[0];
                        sh_d   = {1'b0, sh_q[8:1]};
                        bit_d  = bit_q + 4'd1;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACK: begin
                if (fall) begin
                    cnt_d = '0;
                    if (d_s2_q) begin
                        fail = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (c_s2_q && d_s2_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (fall) begin
                    cnt_d = '0;
                end else if (cnt_q == TMO_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fail) begin
            c_oe_d = 1'b0;
            d_oe_d = 1'b0;
            cnt_d  = '0;
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                // First failure: resend the same byte silently.
                retry_d = 1'b1;
                sh_d    = {~^byte_q, byte_q};
                c_oe_d  = 1'b1;
                state_d = S_INHIBIT;
            end else begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
`else
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
`endif
        end
    end

    assign ps2c_oe = c_oe_q;
    assign ps2d_oe = d_oe_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;
    assign tx_err  = err_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset). It drives the open-drain PS/2 clock and data lines through output-enables and detects the device's acknowledge bit. It sits beside the keyboard receiver in the top level; the receiver must ignore line activity while tx_busy=1.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles the host holds ps2c low before a request (100 us at 50 MHz).
SETUP_CYCLES, 50, clk cycles ps2d is held low (start bit) before ps2c is released.
TIMEOUT_CYCLES, 750000, maximum clk cycles allowed between device clock falling edges (15 ms) before aborting.

Ports:
clk  in  1  system clock (50 MHz).
rst_n  in  1  asynchronous active-low reset.
tx_start  in  1  one-cycle request; accepted only in IDLE.
tx_data  in  8  byte to send; latched when tx_start is accepted.
ps2c_in  in  1  raw PS/2 clock line level.
ps2d_in  in  1  raw PS/2 data line level.
ps2c_oe  out  1  1 = pull PS/2 clock low; 0 = release.
ps2d_oe  out  1  1 = pull PS/2 data low; 0 = release.
tx_busy  out  1  high from acceptance until return to IDLE.
tx_done  out  1  one-cycle pulse when the device has acknowledged.
tx_err  out  1  one-cycle pulse on missing ack or timeout.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; all outputs 0; counters and shift register cleared. Assertion mid-frame releases both lines immediately.
- Synchronisation: ps2c_in and ps2d_in pass through 2-flop synchronisers. A falling edge is the synchronised clock going 1->0 between consecutive cycles.
- Frame: 11 bits. Start=0, d0..d7 LSB first, odd parity (parity = ~^data), stop=1 (line released).
- IDLE: tx_start=1 latches tx_data into a 9-bit shift register {parity, data}, sets tx_busy=1 and enters INHIBIT. tx_start in any other state is ignored with no side effects.
- INHIBIT: ps2c_oe=1 for INHIBIT_CYCLES cycles, then -> REQ.
- REQ: ps2c_oe=1 and ps2d_oe=1 for SETUP_CYCLES cycles, then ps2c_oe=0 -> SHIFT with bit counter=0.
- SHIFT: on each device falling edge, ps2d_oe is set to ~current bit.
  - Edges 1..8 present d0..d7; edge 9 presents parity; edge 10 releases data (stop) -> ACK.
  - ps2d_oe changes only on falling edges.
- ACK: on the next falling edge, sample synchronised data. 0 -> WAIT_IDLE; 1 -> error.
- WAIT_IDLE: wait until both synchronised lines are 1, then pulse tx_done for one cycle, clear tx_busy -> IDLE.
- Timeout: a counter reloads on every falling edge and counts in SHIFT, ACK and WAIT_IDLE. Reaching TIMEOUT_CYCLES triggers an error.
- Error: release both lines, pulse tx_err for one cycle, clear tx_busy -> IDLE.
- tx_done and tx_err are never asserted in the same cycle.
- Counter widths: $clog2 of the largest parameter + 1. No wrap is possible.

Optional Feature:
Macro PS2_TX_RETRY_EN.
- Defined: the first error does not pulse tx_err. The block restarts from INHIBIT with the same latched byte and tx_busy held at 1. A second consecutive error pulses tx_err. A retry counter of 1 bit is cleared on each accepted tx_start.
- Undefined: the first error pulses tx_err and returns to IDLE. No retry logic is synthesised.

Test Plan:
- Basic send: params INHIBIT=20, SETUP=4, TIMEOUT=2000. Send 0xED; device model clocks at 30-cycle period and acks. -> Model samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once; tx_err=0; tx_busy falls the same cycle.
- Parity check: send 0x01 -> model receives parity 0. Send 0xFF -> parity 1. Both complete with tx_done.
- No ack: model leaves data high on the 11th clock. -> tx_err pulses one cycle after that edge; both oe=0. With PS2_TX_RETRY_EN, a second full frame of the same byte is seen first, then tx_err.
- Timeout: model never clocks after REQ. -> tx_err exactly TIMEOUT_CYCLES cycles after ps2c_oe drops; ps2d_oe=0.
- Busy ignore: tx_start with 0x55 during SHIFT of 0xED. -> Transmitted frame is still 0xED; no second frame follows.
- Reset mid-frame: rst_n=0 after edge 5. -> ps2c_oe, ps2d_oe, tx_busy are 0 without waiting for a clk edge. After release, a new send of 0xF4 completes normally.
